seg7_mux_driver: RTL and testbench



---
 rtl/seg7_pkg.sv | 11 +
 rtl/seg7_refresh_timer.sv | 59 +++++
 rtl/seg7_mux_driver.sv | 76 +++++++
 tb/tb_seg7_mux_driver.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the two-digit 7-segment multiplexed driver.
package seg7_pkg;

  typedef logic [6:0] seg7_t;

  localparam seg7_t SEG7_BLANK = 7'h00;
  localparam seg7_t SEG7_ZERO  = 7'h7E;

  typedef enum logic {DEAD, ON} seg7_phase_e;

endpackage

// File: rtl/seg7_refresh_timer.sv
// Slot timer for the multiplexed display: slot counter, digit slot select,
// dead/on phase and the once-per-frame capture strobe.
//
// state | meaning
// DEAD  | leading part of a slot, all digits off (ghost suppression)
// ON    | remainder of the slot, the selected digit is driven
module seg7_refresh_timer
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 50000,
  parameter int DEAD_CYCLES = 500
) (
  input  logic        clk,
  input  logic        rst,
  output logic        slot,
  output seg7_phase_e phase,
  output logic        capture
);

  localparam int CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(REFRESH_DIV - 1);
  localparam logic [CW-1:0] DEAD_END = CW'(DEAD_CYCLES);
  // Without a dead phase the FSM lives in ON, including straight out of reset,
  // so the first digit is driven right after the first edge.
  localparam seg7_phase_e PHASE_RST = (DEAD_CYCLES == 0) ? ON : DEAD;

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          wrap;
  seg7_phase_e   phase_nxt;

  assign wrap    = (cnt == LAST_CNT);
  assign cnt_nxt = wrap ? '0 : cnt + 1'b1;
  assign capture = (cnt == '0) && !slot;

  // Counter, slot toggle at wrap, and phase state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      slot  <= 1'b0;
      phase <= PHASE_RST;
    end else begin
      cnt <= cnt_nxt;
      if (wrap) slot <= ~slot;
      phase <= phase_nxt;
    end
  end

  // Phase follows the counter: DEAD below DEAD_CYCLES, ON from there to the wrap.
  always_comb begin
    phase_nxt = phase;
    case (phase)
      DEAD:    if (cnt_nxt == DEAD_END) phase_nxt = ON;
      ON:      if (wrap && (DEAD_CYCLES != 0)) phase_nxt = DEAD;
      default: phase_nxt = PHASE_RST;
    endcase
  end

endmodule

// File: rtl/seg7_mux_driver.sv
// Two-digit time-multiplexed 7-segment driver. Captures the upstream segment
// codes once per frame into a shadow register, then drives a shared segment
// bus and one enable per digit, with optional pin inversion.
// Optional build macro: SEG7_LZ_BLANK_EN blanks the tens digit when it shows zero.
module seg7_mux_driver
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV    = 50000,
  parameter int DEAD_CYCLES    = 500,
  parameter int ACTIVE_LOW_OUT = 0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [1:0][6:0] s_data,
  output logic [6:0]      seg,
  output logic [1:0]      dig_en,
  output logic            frame_tick
);

  localparam logic POL = (ACTIVE_LOW_OUT != 0);

  logic            slot;
  logic            capture;
  seg7_phase_e     phase;
  logic [1:0][6:0] shadow;
  seg7_t           seg_l;
  logic [1:0]      en_l;
  logic            blank_tens;

  seg7_refresh_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .slot    (slot),
    .phase   (phase),
    .capture (capture)
  );

`ifdef SEG7_LZ_BLANK_EN
  assign blank_tens = (shadow[1] == SEG7_ZERO);
`else
  assign blank_tens = 1'b0;
`endif

  // Shadow copy taken once per frame so a display frame never tears.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) shadow <= '0;
    else if (capture) shadow <= s_data;
  end

  // Logical output levels for the current slot and phase.
  always_comb begin
    seg_l = SEG7_BLANK;
    en_l  = 2'b00;
    if ((phase == ON) && !(slot && blank_tens)) begin
      en_l  = slot ? 2'b10 : 2'b01;
      seg_l = shadow[slot];
    end
  end

  // Registered pins; polarity applied before the flop so pins never glitch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg        <= {7{POL}};
      dig_en     <= {2{POL}};
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_l ^ {7{POL}};
      dig_en     <= en_l ^ {2{POL}};
      frame_tick <= capture;
    end
  end

endmodule

// File: tb/tb_seg7_mux_driver.sv
// Bench for seg7_mux_driver: one instance with an 8-cycle slot and 2-cycle dead
// phase, one active-low instance without dead phase. Expected pin patterns are
// queued per frame; a monitor pops one entry per clock after each edge.
module tb_seg7_mux_driver;

  typedef struct packed {
    logic [6:0] seg;
    logic [1:0] en;
    logic       tick;
  } exp_t;

  logic            clk;
  logic            rst;
  logic [1:0][6:0] s_data;
  logic [6:0]      seg_a, seg_b;
  logic [1:0]      en_a, en_b;
  logic            tick_a, tick_b;

  exp_t qa[$];
  exp_t qb[$];
  int   n_cmp = 0;
  int   n_err = 0;

  seg7_mux_driver #(.REFRESH_DIV(8), .DEAD_CYCLES(2), .ACTIVE_LOW_OUT(0)) dut_a (
    .clk(clk), .rst(rst), .s_data(s_data),
    .seg(seg_a), .dig_en(en_a), .frame_tick(tick_a)
  );

  seg7_mux_driver #(.REFRESH_DIV(8), .DEAD_CYCLES(0), .ACTIVE_LOW_OUT(1)) dut_b (
    .clk(clk), .rst(rst), .s_data(s_data),
    .seg(seg_b), .dig_en(en_b), .frame_tick(tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Queue the pin pattern for n cycles of one frame. t/u: tens/units shown in
  // this frame; pu: units code held in the shadow before this frame's capture
  // (visible for one cycle on the no-dead-phase instance).
  task automatic push_frame(input logic [6:0] t, input logic [6:0] u,
                            input logic [6:0] pu, input int n);
    exp_t ea, eb;
    logic blank;
    blank = 1'b0;
`ifdef SEG7_LZ_BLANK_EN
    blank = (t == 7'h7E);
`endif
    for (int k = 1; k <= n; k++) begin
      ea.tick = (k == 1);
      eb.tick = (k == 1);
      if (k >= 3 && k <= 8) begin
        ea.en = 2'b01; ea.seg = u;
      end else if (k >= 11 && !blank) begin
        ea.en = 2'b10; ea.seg = t;
      end else begin
        ea.en = 2'b00; ea.seg = 7'h00;
      end
      if (k <= 8) begin
        eb.en = 2'b10; eb.seg = (k == 1) ? ~pu : ~u;
      end else if (!blank) begin
        eb.en = 2'b01; eb.seg = ~t;
      end else begin
        eb.en = 2'b11; eb.seg = 7'h7F;
      end
      qa.push_back(ea);
      qb.push_back(eb);
    end
  endtask

  task automatic wait_edges(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_inactive(input string tag);
    chk({tag, "_seg_a"},  32'(seg_a),  32'h00);
    chk({tag, "_en_a"},   32'(en_a),   32'h0);
    chk({tag, "_tick_a"}, 32'(tick_a), 32'h0);
    chk({tag, "_seg_b"},  32'(seg_b),  32'h7F);
    chk({tag, "_en_b"},   32'(en_b),   32'h3);
    chk({tag, "_tick_b"}, 32'(tick_b), 32'h0);
  endtask

  // Monitor: one expected entry per clock while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (!rst && qa.size() > 0 && qb.size() > 0) begin
        e = qa.pop_front();
        chk("seg_a",  32'(seg_a),  32'(e.seg));
        chk("en_a",   32'(en_a),   32'(e.en));
        chk("tick_a", 32'(tick_a), 32'(e.tick));
        e = qb.pop_front();
        chk("seg_b",  32'(seg_b),  32'(e.seg));
        chk("en_b",   32'(en_b),   32'(e.en));
        chk("tick_b", 32'(tick_b), 32'(e.tick));
      end
    end
  end

  // Stimulus.
  initial begin
    rst    = 1'b1;
    s_data = {7'h30, 7'h7E};
    wait_edges(3);
    chk_inactive("reset");

    push_frame(7'h30, 7'h7E, 7'h00, 16);
    push_frame(7'h6D, 7'h5B, 7'h7E, 16);
    push_frame(7'h6D, 7'h5B, 7'h5B, 12);
    rst = 1'b0;

    // Mid-slot-0 change must not reach the current frame.
    wait_edges(5);
    s_data = {7'h6D, 7'h5B};

    // Edge 44: third frame, tens slot showing; reset asynchronously.
    wait_edges(39);
    rst = 1'b1;
    #1;
    chk_inactive("midreset");
    chk("drain_a_mid", 32'(qa.size()), 32'd0);
    s_data = {7'h30, 7'h7E};
    wait_edges(3);
    chk_inactive("midreset_hold");

    push_frame(7'h30, 7'h7E, 7'h00, 16);
    push_frame(7'h7E, 7'h33, 7'h7E, 16);
    rst = 1'b0;
    wait_edges(5);
    s_data = {7'h7E, 7'h33};
    wait_edges(27);

    chk("drain_a", 32'(qa.size()), 32'd0);
    chk("drain_b", 32'(qb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
